// File: rtl/dac_frame_sequencer_if.sv
// Sample handshake bundle between the sample source and the DAC frame sequencer.
interface dac_frame_sequencer_if #(
  parameter int DATA_W = 24
) ();
  logic [DATA_W-1:0] sample_l_i;
  logic [DATA_W-1:0] sample_r_i;
  logic              sample_valid_i;
  logic              sample_ready_o;

  modport master (
    output sample_l_i,
    output sample_r_i,
    output sample_valid_i,
    input  sample_ready_o
  );

  modport slave (
    input  sample_l_i,
    input  sample_r_i,
    input  sample_valid_i,
    output sample_ready_o
  );
endinterface

// File: rtl/dac_frame_sequencer.sv
// I2S frame sequencer: buffers one stereo sample pair and serializes it to a DAC
// as bclk/lrck/sdata, one frame of 2*SLOT_W bit clocks per pair, MSB first with
// the I2S one-bit delay. Empty buffer at a frame start plays silence and flags
// an underrun.
module dac_frame_sequencer #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  dac_frame_sequencer_if.slave  smp,
  output logic                  bclk_o,
  output logic                  lrck_o,
  output logic                  sdata_o,
  output logic                  underrun_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               bclk_q, bclk_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               underrun_q, underrun_d;
  logic               hold_full_q, hold_full_d;
  logic [DATA_W-1:0]  hold_l_q, hold_l_d;
  logic [DATA_W-1:0]  hold_r_q, hold_r_d;
  logic [DATA_W-1:0]  sh_l_q, sh_l_d;
  logic [DATA_W-1:0]  sh_r_q, sh_r_d;

  logic               fall_s;
  logic               frame_start_s;
  logic               accept_s;
  logic [BIT_W-1:0]   nxt_bit_s;
  logic [BIT_W-1:0]   slot_pos_s;

  // Ready depends only on the registered buffer flag, never on valid.
  assign smp.sample_ready_o = ~hold_full_q;
  assign bclk_o     = bclk_q;
  assign lrck_o     = lrck_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

  // Next-state: divider, bit counter, serializer, frame loading and handshake.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    bclk_d        = bclk_q;
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    underrun_d    = 1'b0;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    sh_l_d        = sh_l_q;
    sh_r_d        = sh_r_q;
    fall_s        = 1'b0;
    frame_start_s = 1'b0;
    accept_s      = smp.sample_valid_i & ~hold_full_q;
    nxt_bit_s     = bit_cnt_q + BIT_ONE;
    slot_pos_s    = (nxt_bit_s >= SLOT_LEN) ? (nxt_bit_s - SLOT_LEN) : nxt_bit_s;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bclk_d    = 1'b0;
        lrck_d    = 1'b0;
        sdata_d   = 1'b0;
        if (enable_i) begin
          state_d       = ST_RUN;
          frame_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        state_d = enable_i ? ST_RUN : ST_DRAIN;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          bclk_d    = ~bclk_q;
          fall_s    = bclk_q;
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
        if (fall_s) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (state_q == ST_DRAIN) begin
              // Draining: finish quietly instead of starting another frame.
              state_d = ST_IDLE;
              lrck_d  = 1'b0;
              sdata_d = 1'b0;
            end else begin
              frame_start_s = 1'b1;
            end
          end else begin
            bit_cnt_d = nxt_bit_s;
            lrck_d    = (nxt_bit_s >= SLOT_LEN);
            if ((slot_pos_s != '0) && (slot_pos_s <= DATA_LAST)) begin
              if (nxt_bit_s >= SLOT_LEN) begin
                sdata_d = sh_r_q[DATA_W-1];
                sh_r_d  = {sh_r_q[DATA_W-2:0], 1'b0};
              end else begin
                sdata_d = sh_l_q[DATA_W-1];
                sh_l_d  = {sh_l_q[DATA_W-2:0], 1'b0};
              end
            end else begin
              // Delay bit and slot padding are silent.
              sdata_d = 1'b0;
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_start_s) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b0;
      lrck_d    = 1'b0;
      sdata_d   = 1'b0;
      if (hold_full_q) begin
        sh_l_d      = hold_l_q;
        sh_r_d      = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        sh_l_d     = '0;
        sh_r_d     = '0;
        underrun_d = 1'b1;
      end
    end else begin
      underrun_d = 1'b0;
    end

    // An accept can only happen with the buffer empty, so it never collides
    // with the frame-start clear above; a same-cycle underrun frame stays silent.
    if (accept_s) begin
      hold_full_d = 1'b1;
      hold_l_d    = smp.sample_l_i;
      hold_r_d    = smp.sample_r_i;
    end else begin
      hold_l_d = hold_l_d;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
    end
  end

endmodule

// File: doc/dac_frame_sequencer.md
DAC_FRAME_SEQUENCER -- requirements
Module: dac_frame_sequencer

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits per channel.
REQ-002 Parameter SLOT_W, default 32: bclk periods per channel slot; SHALL satisfy SLOT_W >= DATA_W+1.
REQ-003 Parameter BCLK_DIV, default 4: clk cycles per bclk half-period; SHALL be >= 2.
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 enable_i  input  1  run request; level-sensitive.
REQ-007 sample_l_i  input  DATA_W  left sample, two's complement.
REQ-008 sample_r_i  input  DATA_W  right sample, two's complement.
REQ-009 sample_valid_i  input  1  sample pair on sample_l_i/sample_r_i is valid.
REQ-010 sample_ready_o  output  1  holding buffer empty; a pair is accepted when valid and ready are both high on a clk edge.
REQ-011 bclk_o  output  1  serial bit clock to the DAC.
REQ-012 lrck_o  output  1  channel select: 0 = left slot, 1 = right slot.
REQ-013 sdata_o  output  1  serial data, I2S format, MSB first.
REQ-014 underrun_o  output  1  one-cycle pulse when a frame starts with the holding buffer empty.

Function
REQ-015 States: IDLE, RUN, DRAIN; all outputs registered; sample_ready_o SHALL equal the inverted registered hold-full flag, with no combinational path from sample_valid_i.
REQ-016 IDLE: bclk_o=0, lrck_o=0, sdata_o=0, divider and bit counters held at 0; handshake stays active so the holding buffer can be pre-filled.
REQ-017 IDLE -> RUN when enable_i=1; that cycle is a frame-start event.
REQ-018 Divider in RUN/DRAIN: div_cnt counts 0..BCLK_DIV-1 and wraps; at div_cnt=BCLK_DIV-1, bclk_o toggles.
- A 1->0 toggle is a falling event.
- A 0->1 toggle is a rising event.
REQ-019 bit_cnt (0..2*SLOT_W-1) SHALL advance only on falling events and wrap from 2*SLOT_W-1 to 0; the wrap is a frame-start event.
REQ-020 lrck_o and sdata_o SHALL change only in the cycle of a falling event or a frame-start event, never on a rising event.
REQ-021 lrck_o = 0 for bit_cnt 0..SLOT_W-1 and 1 for bit_cnt SLOT_W..2*SLOT_W-1.
REQ-022 For slot position k = bit_cnt mod SLOT_W, sdata_o SHALL be:
- k=0: 0 (I2S one-bit delay).
- k=1..DATA_W: channel word bit DATA_W-k (MSB first).
- k>DATA_W: 0.
REQ-023 Frame-start event, holding buffer full: the pair is copied to the left/right shift registers and the hold-full flag clears in the same cycle.
REQ-024 Frame-start event, holding buffer empty: the shift registers load all-zero and underrun_o pulses for exactly that cycle.
REQ-025 A handshake in the same cycle as a frame-start event with an empty buffer SHALL fill the holding buffer and SHALL NOT affect the frame just started; that frame still underruns.
REQ-026 A handshake in the same cycle as a frame-start event with a full buffer cannot occur, because sample_ready_o=0 in that cycle.
REQ-027 RUN -> DRAIN when enable_i=0; DRAIN completes the current frame.
REQ-028 At the bit_cnt wrap in DRAIN, the block enters IDLE instead of starting a frame: no load, no underrun pulse.
REQ-029 DRAIN -> RUN if enable_i returns to 1 before the wrap; frame timing is unchanged.
REQ-030 Frame length SHALL be exactly 4*SLOT_W*BCLK_DIV clk cycles (512 at defaults); bclk_o duty cycle SHALL be exactly 50%.
REQ-031 The holding buffer SHALL retain its content across IDLE and DRAIN.

Reset
REQ-032 rst_ni=0 SHALL immediately set:
- state=IDLE, all counters 0, hold-full flag 0, shift registers 0.
- bclk_o=0, lrck_o=0, sdata_o=0, underrun_o=0, sample_ready_o=1.
REQ-033 Reset asserted mid-frame SHALL discard the frame and buffered data; after release the block restarts per REQ-017 with the holding buffer empty.

Verification
REQ-034 Reset, then hold enable_i=0 for 100 cycles -> every output stays at its reset value; sample_ready_o=1.
REQ-035 Pre-load L=24'hA5A5A5, R=24'h123456, then enable_i=1 -> the following SHALL all hold:
- bclk_o period is 8 clk cycles.
- lrck_o falls every 512 cycles.
- Left slot serializes 0, then A5A5A5 MSB first, then 7 zeros; right slot likewise with 123456.
- underrun_o stays 0 for that frame.
REQ-036 Enable with the holding buffer empty -> the first frame is all zeros; underrun_o pulses once in the enable cycle.
REQ-037 Feed a new pair each frame for 4 frames with sample_valid_i permanently high -> exactly one accept per frame and no underrun.
REQ-038 Drop enable_i at bit_cnt=10 -> the frame completes all 64 bclk periods, then IDLE outputs appear; the buffered pair is still present when the block is re-enabled.
REQ-039 Assert rst_ni=0 at bit_cnt=40 -> all outputs are 0 within the same cycle (sample_ready_o=1); re-enable after release and a frame-start event occurs correctly.
